regfile_rename: RTL and testbench

Architectural register file with per-register rename tags; receiving end of the ROB commit interface and query responder for the decoder. Holds 32 x 32-bit integer registers, a busy bit and a ROB reorder tag per register. The decoder reads operand value/busy/tag and renames destinations at dispatch. The ROB retires results in order through the commit port, and the ROB flush clears all pending renames.

---
 rtl/regfile_rename.sv | 74 +++++++
 tb/tb_regfile_rename.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// regfile_rename: 32 x 32-bit architectural register file with per-register busy/ROB-tag rename state.
// Optional REGFILE_COMMIT_BYPASS_EN forwards a tag-matching commit to same-cycle queries.
module regfile_rename #(
  parameter int REG_NUM = 32,
  parameter int TAG_W = 4
) (
  input  logic             in_clk,
  input  logic             in_rst_n,
  input  logic             in_rdy,
  input  logic             in_flush_enable,
  input  logic [4:0]       in_decoder_rs,
  input  logic [4:0]       in_decoder_rt,
  output logic             out_decoder_rs_busy,
  output logic             out_decoder_rt_busy,
  output logic [TAG_W-1:0] out_decoder_rs_reorder,
  output logic [TAG_W-1:0] out_decoder_rt_reorder,
  output logic [31:0]      out_decoder_rs_value,
  output logic [31:0]      out_decoder_rt_value,
  input  logic             in_decoder_rename_enable,
  input  logic [4:0]       in_decoder_rd,
  input  logic [TAG_W-1:0] in_decoder_reorder,
  input  logic             in_rob_commit_enable,
  input  logic [4:0]       in_rob_commit_rd,
  input  logic [31:0]      in_rob_commit_value,
  input  logic [TAG_W-1:0] in_rob_commit_reorder,
  output logic [31:0]      out_commit_count
);
`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [31:0]      value [REG_NUM];
  logic [TAG_W-1:0] tag [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic commit, rename, retire;
  assign commit = in_rdy && in_rob_commit_enable && in_rob_commit_rd != 5'd0;
  assign rename = in_rdy && in_decoder_rename_enable && in_decoder_rd != 5'd0 && !in_flush_enable;
  assign retire = busy[in_rob_commit_rd] && tag[in_rob_commit_rd] == in_rob_commit_reorder;
  // Later non-blocking writes win: flush, then commit release, then rename.
  always_ff @(posedge in_clk or negedge in_rst_n)
    if (!in_rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value[i] <= '0;
        tag[i] <= '0;
      end
      busy <= '0;
      out_commit_count <= '0;
    end else if (in_rdy) begin
      if (in_flush_enable) begin
        busy <= '0;
        for (int i = 0; i < REG_NUM; i++) tag[i] <= '0;
      end
      if (commit) begin
        value[in_rob_commit_rd] <= in_rob_commit_value;
        out_commit_count <= out_commit_count + 32'd1;
        if (retire) begin
          busy[in_rob_commit_rd] <= 1'b0;
          tag[in_rob_commit_rd] <= '0;
        end
      end
      if (rename) begin
        busy[in_decoder_rd] <= 1'b1;
        tag[in_decoder_rd] <= in_decoder_reorder;
      end
    end
  function automatic logic [TAG_W+32:0] query(input logic [4:0] r);
    logic hit;
    hit = BYP && commit && r == in_rob_commit_rd && retire;
    return r == 5'd0 ? '0 : hit ? {1'b0, {TAG_W{1'b0}}, in_rob_commit_value} : {busy[r], tag[r], value[r]};
  endfunction
  assign {out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value} = query(in_decoder_rs);
  assign {out_decoder_rt_busy, out_decoder_rt_reorder, out_decoder_rt_value} = query(in_decoder_rt);
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: table vectors, hand sequences and random stimulus against a spec-level model.
module tb_regfile_rename;
`ifdef REGFILE_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic in_clk = 0, in_rst_n = 0, in_rdy = 0, in_flush_enable = 0;
  logic [4:0] in_decoder_rs = 0, in_decoder_rt = 0, in_decoder_rd = 0, in_rob_commit_rd = 0;
  logic out_decoder_rs_busy, out_decoder_rt_busy;
  logic [3:0] out_decoder_rs_reorder, out_decoder_rt_reorder;
  logic [31:0] out_decoder_rs_value, out_decoder_rt_value, out_commit_count;
  logic in_decoder_rename_enable = 0, in_rob_commit_enable = 0;
  logic [3:0] in_decoder_reorder = 0, in_rob_commit_reorder = 0;
  logic [31:0] in_rob_commit_value = 0;

  regfile_rename dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_rdy(in_rdy), .in_flush_enable(in_flush_enable),
    .in_decoder_rs(in_decoder_rs), .in_decoder_rt(in_decoder_rt),
    .out_decoder_rs_busy(out_decoder_rs_busy), .out_decoder_rt_busy(out_decoder_rt_busy),
    .out_decoder_rs_reorder(out_decoder_rs_reorder), .out_decoder_rt_reorder(out_decoder_rt_reorder),
    .out_decoder_rs_value(out_decoder_rs_value), .out_decoder_rt_value(out_decoder_rt_value),
    .in_decoder_rename_enable(in_decoder_rename_enable), .in_decoder_rd(in_decoder_rd),
    .in_decoder_reorder(in_decoder_reorder), .in_rob_commit_enable(in_rob_commit_enable),
    .in_rob_commit_rd(in_rob_commit_rd), .in_rob_commit_value(in_rob_commit_value),
    .in_rob_commit_reorder(in_rob_commit_reorder), .out_commit_count(out_commit_count)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {
    bit rdy, fl, ren; logic [4:0] rd; logic [3:0] reo;
    bit cen; logic [4:0] crd; logic [31:0] cval; logic [3:0] creo;
    logic [4:0] rs, rt;
    bit eb; logic [3:0] et; logic [31:0] ev, ec;
  } vec_t;

  int total = 0, bad = 0;
  logic [31:0] m_val [32];
  bit          m_busy [32];
  logic [3:0]  m_tag [32];
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    m_cnt = 0;
  endtask

  // Expected query answer for register r given the stored model and the inputs currently driven.
  task automatic check_q(input string nm, input logic [4:0] r, input vec_t v,
                         input logic b, input logic [3:0] t, input logic [31:0] val);
    bit eb; logic [3:0] et; logic [31:0] ev;
    eb = m_busy[r]; et = m_tag[r]; ev = m_val[r];
    if (BYP && v.rdy && v.cen && v.crd == r && r != 0 && m_busy[r] && m_tag[r] == v.creo) begin
      eb = 0; et = 0; ev = v.cval;
    end
    if (r == 0) begin eb = 0; et = 0; ev = 0; end
    chk({nm, "_busy"}, 32'(b), 32'(eb));
    chk({nm, "_reorder"}, 32'(t), 32'(et));
    chk({nm, "_value"}, val, ev);
  endtask

  task automatic model_edge(input vec_t v);
    bit release_tag;
    if (!v.rdy) return;
    release_tag = 0;
    if (v.cen && v.crd != 0) begin
      release_tag = m_busy[v.crd] && m_tag[v.crd] == v.creo;
      m_val[v.crd] = v.cval;
      m_cnt = m_cnt + 1;
    end
    if (v.fl) for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
    if (release_tag) begin m_busy[v.crd] = 0; m_tag[v.crd] = 0; end
    if (v.ren && v.rd != 0 && !v.fl) begin m_busy[v.rd] = 1; m_tag[v.rd] = v.reo; end
  endtask

  task automatic apply(input vec_t v);
    in_rdy = v.rdy; in_flush_enable = v.fl; in_decoder_rename_enable = v.ren;
    in_decoder_rd = v.rd; in_decoder_reorder = v.reo; in_rob_commit_enable = v.cen;
    in_rob_commit_rd = v.crd; in_rob_commit_value = v.cval; in_rob_commit_reorder = v.creo;
    in_decoder_rs = v.rs; in_decoder_rt = v.rt;
  endtask

  task automatic step(input vec_t v, input bit use_exp);
    apply(v);
    #1;
    check_q("rs", v.rs, v, out_decoder_rs_busy, out_decoder_rs_reorder, out_decoder_rs_value);
    check_q("rt", v.rt, v, out_decoder_rt_busy, out_decoder_rt_reorder, out_decoder_rt_value);
    chk("count", out_commit_count, m_cnt);
    if (use_exp) begin
      chk("vec_busy", 32'(out_decoder_rs_busy), 32'(v.eb));
      chk("vec_reorder", 32'(out_decoder_rs_reorder), 32'(v.et));
      chk("vec_value", out_decoder_rs_value, v.ev);
      chk("vec_count", out_commit_count, v.ec);
    end
    @(posedge in_clk);
    model_edge(v);
    @(negedge in_clk);
  endtask

  function automatic vec_t mk(bit rdy, bit fl, bit ren, int rd, int reo, bit cen, int crd, int cval,
                              int creo, int rs, int rt, bit eb, int et, int ev, int ec);
    vec_t v;
    v.rdy = rdy; v.fl = fl; v.ren = ren; v.rd = 5'(rd); v.reo = 4'(reo);
    v.cen = cen; v.crd = 5'(crd); v.cval = 32'(cval); v.creo = 4'(creo);
    v.rs = 5'(rs); v.rt = 5'(rt); v.eb = eb; v.et = 4'(et); v.ev = 32'(ev); v.ec = 32'(ec);
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    vec_t v;
    model_reset();
    tbl[0]  = mk(1,0,0,0,0, 0,0,0,0,       5,0,  0,0,0,0);
    tbl[1]  = mk(1,0,1,5,3, 0,0,0,0,       5,5,  0,0,0,0);
    tbl[2]  = mk(1,0,0,0,0, 0,0,0,0,       5,0,  1,3,0,0);
    tbl[3]  = mk(1,0,0,0,0, 1,5,'h1234,3,  5,0,  !BYP, BYP ? 0 : 3, BYP ? 'h1234 : 0, 0);
    tbl[4]  = mk(1,0,0,0,0, 0,0,0,0,       5,0,  0,0,'h1234,1);
    tbl[5]  = mk(1,0,1,7,2, 0,0,0,0,       7,0,  0,0,0,1);
    tbl[6]  = mk(1,0,1,7,4, 0,0,0,0,       7,0,  1,2,0,1);
    tbl[7]  = mk(1,0,0,0,0, 1,7,'hAA,2,    7,0,  1,4,0,1);
    tbl[8]  = mk(1,0,0,0,0, 0,0,0,0,       7,0,  1,4,'hAA,2);
    tbl[9]  = mk(1,0,1,9,6, 0,0,0,0,       9,0,  0,0,0,2);
    tbl[10] = mk(1,1,1,10,7, 1,9,'h55,6,   9,10, !BYP, BYP ? 0 : 6, BYP ? 'h55 : 0, 2);
    tbl[11] = mk(1,0,0,0,0, 0,0,0,0,       9,10, 0,0,'h55,3);
    tbl[12] = mk(1,0,0,0,0, 1,0,'hFFFF,1,  0,7,  0,0,0,3);
    tbl[13] = mk(1,0,0,0,0, 0,0,0,0,       0,7,  0,0,0,3);
    tbl[14] = mk(0,0,1,3,5, 1,3,'h99,1,    3,0,  0,0,0,3);
    tbl[15] = mk(1,0,0,0,0, 0,0,0,0,       3,0,  0,0,0,3);
    tbl[16] = mk(1,0,1,4,5, 0,0,0,0,       4,4,  0,0,0,3);
    tbl[17] = mk(1,0,0,0,0, 1,4,'h77,5,    4,0,  !BYP, BYP ? 0 : 5, BYP ? 'h77 : 0, 3);
    tbl[18] = mk(1,0,0,0,0, 0,0,0,0,       4,0,  0,0,'h77,4);
    tbl[19] = mk(1,0,1,6,1, 0,0,0,0,       6,0,  0,0,0,4);
    tbl[20] = mk(1,0,1,6,2, 1,6,'h66,1,    6,0,  !BYP, BYP ? 0 : 1, BYP ? 'h66 : 0, 4);
    tbl[21] = mk(1,0,0,0,0, 0,0,0,0,       6,0,  1,2,'h66,5);

    // Reset state while reset is held.
    in_decoder_rs = 5; in_decoder_rt = 0;
    @(negedge in_clk); #1;
    chk("rst_rs_busy", 32'(out_decoder_rs_busy), 0);
    chk("rst_rs_value", out_decoder_rs_value, 0);
    chk("rst_rt_reorder", 32'(out_decoder_rt_reorder), 0);
    chk("rst_count", out_commit_count, 0);
    @(negedge in_clk);
    in_rst_n = 1;

    for (int i = 0; i < 22; i++) step(tbl[i], 1);

    // Randomized traffic; small register range to force collisions.
    for (int n = 0; n < 600; n++) begin
      v = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0);
      v.rdy = ($urandom_range(0, 7) != 0);
      v.fl = ($urandom_range(0, 19) == 0);
      v.ren = $urandom_range(0, 1);
      v.rd = 5'($urandom_range(0, 7));
      v.reo = 4'($urandom_range(1, 15));
      v.cen = $urandom_range(0, 1);
      v.crd = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      v.cval = $urandom;
      v.creo = $urandom_range(0, 1) ? m_tag[v.crd] : 4'($urandom_range(1, 15));
      v.rs = $urandom_range(0, 1) ? v.crd : 5'($urandom_range(0, 7));
      v.rt = 5'($urandom_range(0, 31));
      step(v, 0);
    end

    // Asynchronous reset in the middle of a cycle, with traffic still driven.
    v = mk(1,0,1,2,9, 1,5,'hBEEF,3, 5,6, 0,0,0,0);
    apply(v);
    #2 in_rst_n = 0;
    #1;
    chk("async_rs_busy", 32'(out_decoder_rs_busy), 0);
    chk("async_rs_reorder", 32'(out_decoder_rs_reorder), 0);
    chk("async_rs_value", out_decoder_rs_value, 0);
    chk("async_rt_value", out_decoder_rt_value, 0);
    chk("async_count", out_commit_count, 0);
    model_reset();
    @(negedge in_clk);
    in_rst_n = 1;
    step(mk(1,0,0,0,0, 0,0,0,0, 5,7, 0,0,0,0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
